// File: rtl/bfly_stage.sv
// rtl/bfly_stage.sv - radix-2 DIF butterfly stage: first half of each frame is delayed
// and combined with the second half as sum and difference, with optional scaling and saturation.
module bfly_stage #(
   parameter int IN_WIDTH  = 9,
   parameter int OUT_WIDTH = 10,
   parameter int NUM       = 16,
   parameter int DATA      = 512,
   parameter int COUNT     = DATA / NUM,
   parameter int DELAY     = COUNT / 2,
   parameter int SCALE     = 0,
   parameter int SAT       = 1
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [NUM-1:0][IN_WIDTH-1:0]        din_i,
   input  logic [NUM-1:0][IN_WIDTH-1:0]        din_q,
   input  logic                                valid_in,
   input  logic                                sync_in,
   output logic [NUM-1:0][OUT_WIDTH-1:0]       do1_re,
   output logic [NUM-1:0][OUT_WIDTH-1:0]       do1_im,
   output logic [NUM-1:0][OUT_WIDTH-1:0]       do2_re,
   output logic [NUM-1:0][OUT_WIDTH-1:0]       do2_im,
   output logic                                valid_out,
   output logic                                last_out,
   output logic                                frame_err
);

   localparam int SW   = IN_WIDTH + 1;
   localparam int XW   = SW + 1;
   localparam int CW   = $clog2(COUNT);
   localparam int AW   = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam int OMAX = 2 ** (OUT_WIDTH - 1) - 1;
   localparam int OMIN = -(2 ** (OUT_WIDTH - 1));

   logic [CW-1:0]                 cnt;
   logic [CW-1:0]                 idx;
   logic                          wr_phase;
   logic [AW-1:0]                 wa;
   logic [AW-1:0]                 ra;
   logic [NUM-1:0][IN_WIDTH-1:0]  dl_i [DELAY];
   logic [NUM-1:0][IN_WIDTH-1:0]  dl_q [DELAY];
   logic [NUM-1:0][IN_WIDTH-1:0]  a_i;
   logic [NUM-1:0][IN_WIDTH-1:0]  a_q;
   logic [NUM-1:0][OUT_WIDTH-1:0] s_re, s_im, d_re, d_im;

   function automatic logic signed [SW-1:0] ext(input logic [IN_WIDTH-1:0] x);
      ext = $signed({x[IN_WIDTH-1], x});
   endfunction

   // One extra bit of headroom keeps the rounding add exact even for the largest difference.
   function automatic logic [OUT_WIDTH-1:0] fit(input logic signed [SW-1:0] x);
      logic signed [XW-1:0] xe;
      logic signed [XW-1:0] r;
      int                   rv;
      xe = $signed({x[SW-1], x});
      r  = (SCALE != 0) ? ((xe + XW'(1)) >>> 1) : xe;
      rv = int'(r);
      if (SAT != 0 && rv > OMAX)
         fit = OUT_WIDTH'(OMAX);
      else if (SAT != 0 && rv < OMIN)
         fit = OUT_WIDTH'(OMIN);
      else
         fit = OUT_WIDTH'(r);
   endfunction

   assign idx      = sync_in ? '0 : cnt;
   assign wr_phase = (idx < CW'(DELAY));
   assign wa       = AW'(idx);
   assign ra       = AW'(idx - CW'(DELAY));
   assign a_i      = dl_i[ra];
   assign a_q      = dl_q[ra];

   always_comb begin
      s_re = '0;
      s_im = '0;
      d_re = '0;
      d_im = '0;
      for (int k = 0; k < NUM; k++) begin
         s_re[k] = fit(ext(a_i[k]) + ext(din_i[k]));
         s_im[k] = fit(ext(a_q[k]) + ext(din_q[k]));
         d_re[k] = fit(ext(a_i[k]) - ext(din_i[k]));
         d_im[k] = fit(ext(a_q[k]) - ext(din_q[k]));
      end
   end

   // The delay line needs no reset: every slot is rewritten before it is read.
   always_ff @(posedge clk) begin
      if (rstn && valid_in && wr_phase) begin
         dl_i[wa] <= din_i;
         dl_q[wa] <= din_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt       <= '0;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
         frame_err <= 1'b0;
         do1_re    <= '0;
         do1_im    <= '0;
         do2_re    <= '0;
         do2_im    <= '0;
      end else begin
         valid_out <= 1'b0;
         last_out  <= 1'b0;
         frame_err <= 1'b0;
         if (valid_in) begin
            cnt       <= (idx == CW'(COUNT - 1)) ? '0 : idx + CW'(1);
            frame_err <= sync_in && (cnt != '0);
            if (!wr_phase) begin
               valid_out <= 1'b1;
               last_out  <= (idx == CW'(COUNT - 1));
               do1_re    <= s_re;
               do1_im    <= s_im;
               do2_re    <= d_re;
               do2_im    <= d_im;
            end
         end
      end
   end

endmodule

// File: tb/tb_bfly_stage.sv
// tb/tb_bfly_stage.sv - self-checking bench for bfly_stage: four configurations driven in
// parallel and compared against an integer reference model of frame positions and butterfly math.
module tb_bfly_stage;

   localparam int ND  = 4;
   localparam int NL  = 4;
   localparam int FR  = 8;
   localparam int HF  = FR / 2;
   localparam int OW [ND] = '{10, 9, 9, 9};
   localparam int SC [ND] = '{0, 0, 0, 1};
   localparam int ST [ND] = '{1, 1, 0, 1};

   logic                clk = 1'b0;
   logic                rstn;
   logic [NL-1:0][8:0]  din_i;
   logic [NL-1:0][8:0]  din_q;
   logic                valid_in;
   logic                sync_in;

   int o1r [ND][NL], o1i [ND][NL], o2r [ND][NL], o2i [ND][NL];
   int ov [ND], ol [ND], oe [ND];

   int e1r [ND][NL], e1i [ND][NL], e2r [ND][NL], e2i [ND][NL];
   int ev, el, ee;
   int m_pos;
   int buf_re [HF][NL], buf_im [HF][NL];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      logic [NL-1:0][OW[g]-1:0] do1_re, do1_im, do2_re, do2_im;
      logic valid_out, last_out, frame_err;

      bfly_stage #(
         .IN_WIDTH(9), .OUT_WIDTH(OW[g]), .NUM(NL), .DATA(NL * FR),
         .SCALE(SC[g]), .SAT(ST[g])
      ) u_dut (
         .clk(clk), .rstn(rstn), .din_i(din_i), .din_q(din_q),
         .valid_in(valid_in), .sync_in(sync_in),
         .do1_re(do1_re), .do1_im(do1_im), .do2_re(do2_re), .do2_im(do2_im),
         .valid_out(valid_out), .last_out(last_out), .frame_err(frame_err)
      );

      assign ov[g] = int'(valid_out);
      assign ol[g] = int'(last_out);
      assign oe[g] = int'(frame_err);
      for (genvar k = 0; k < NL; k++) begin : g_lane
         assign o1r[g][k] = int'($signed(do1_re[k]));
         assign o1i[g][k] = int'($signed(do1_im[k]));
         assign o2r[g][k] = int'($signed(do2_re[k]));
         assign o2i[g][k] = int'($signed(do2_im[k]));
      end
   end

   // Exact result, optionally halved with round-half-up, then clamped or wrapped to the output width.
   function automatic int fit(int x, int g);
      int r, mx, mn, m;
      r  = (SC[g] != 0) ? ((x + 1) >>> 1) : x;
      mx = (1 << (OW[g] - 1)) - 1;
      mn = -(1 << (OW[g] - 1));
      if (r >= mn && r <= mx) return r;
      if (ST[g] != 0) return (r > mx) ? mx : mn;
      m = r & ((1 << OW[g]) - 1);
      if (m > mx) m -= (1 << OW[g]);
      return m;
   endfunction

   task automatic check(string tag, int obs, int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model(bit v, bit s, bit r);
      int p, a, b;
      ev = 0; el = 0; ee = 0;
      if (!r) begin
         m_pos = 0;
         for (int g = 0; g < ND; g++)
            for (int k = 0; k < NL; k++) begin
               e1r[g][k] = 0; e1i[g][k] = 0; e2r[g][k] = 0; e2i[g][k] = 0;
            end
      end else if (v) begin
         p  = s ? 0 : m_pos;
         ee = (s && m_pos != 0) ? 1 : 0;
         if (p < HF) begin
            for (int k = 0; k < NL; k++) begin
               buf_re[p][k] = int'($signed(din_i[k]));
               buf_im[p][k] = int'($signed(din_q[k]));
            end
         end else begin
            ev = 1;
            el = (p == FR - 1) ? 1 : 0;
            for (int g = 0; g < ND; g++)
               for (int k = 0; k < NL; k++) begin
                  a = buf_re[p - HF][k]; b = int'($signed(din_i[k]));
                  e1r[g][k] = fit(a + b, g);
                  e2r[g][k] = fit(a - b, g);
                  a = buf_im[p - HF][k]; b = int'($signed(din_q[k]));
                  e1i[g][k] = fit(a + b, g);
                  e2i[g][k] = fit(a - b, g);
               end
         end
         m_pos = (p + 1) % FR;
      end
   endtask

   task automatic step(bit v, bit s, bit r);
      rstn = r; valid_in = v; sync_in = s;
      @(posedge clk);
      #1;
      model(v, s, r);
      for (int g = 0; g < ND; g++) begin
         check($sformatf("valid_out[d%0d]", g), ov[g], ev);
         check($sformatf("last_out[d%0d]", g), ol[g], el);
         check($sformatf("frame_err[d%0d]", g), oe[g], ee);
         for (int k = 0; k < NL; k++) begin
            check($sformatf("do1_re[d%0d][%0d]", g, k), o1r[g][k], e1r[g][k]);
            check($sformatf("do1_im[d%0d][%0d]", g, k), o1i[g][k], e1i[g][k]);
            check($sformatf("do2_re[d%0d][%0d]", g, k), o2r[g][k], e2r[g][k]);
            check($sformatf("do2_im[d%0d][%0d]", g, k), o2i[g][k], e2i[g][k]);
         end
      end
   endtask

   task automatic set_basic(int j);
      for (int k = 0; k < NL; k++) begin
         din_i[k] = (j < HF) ? 9'(10 * j + k) : 9'd1;
         din_q[k] = 9'd0;
      end
   endtask

   task automatic set_rand();
      for (int k = 0; k < NL; k++) begin
         case ($urandom_range(0, 3))
            0:       din_i[k] = 9'h0FF;
            1:       din_i[k] = 9'h100;
            default: din_i[k] = 9'($urandom);
         endcase
         din_q[k] = 9'($urandom);
      end
   endtask

   initial begin
      rstn = 1'b0; valid_in = 1'b0; sync_in = 1'b0;
      din_i = '0; din_q = '0;
      m_pos = 0;

      // reset state
      step(0, 0, 0);
      step(0, 0, 0);

      // basic frame
      for (int j = 0; j < FR; j++) begin
         set_basic(j);
         step(1, j == 0, 1);
      end

      // same frame with a three-cycle gap between beats 5 and 6
      for (int j = 0; j < FR; j++) begin
         set_basic(j);
         step(1, j == 0, 1);
         if (j == 5) begin
            step(0, 0, 1);
            step(0, 0, 1);
            step(0, 0, 1);
         end
      end

      // reset for two edges mid-stream with valid held high, then a frame without sync
      for (int j = 0; j < 3; j++) begin
         set_rand();
         step(1, j == 0, 1);
      end
      set_rand();
      step(1, 0, 0);
      step(1, 0, 0);
      for (int j = 0; j < FR; j++) begin
         set_basic(j);
         step(1, 0, 1);
      end

      // overflow corners: saturation, wrap and rounding
      for (int j = 0; j < FR; j++) begin
         set_rand();
         if (j == 0) begin
            din_i[0] = 9'h0FF; din_i[1] = 9'h100; din_i[2] = 9'd3; din_i[3] = -9'sd3;
            din_q[0] = 9'h100; din_q[1] = 9'h0FF;
         end else if (j == HF) begin
            din_i[0] = 9'h0FF; din_i[1] = 9'h0FF; din_i[2] = 9'd0; din_i[3] = 9'd0;
            din_q[0] = 9'h100; din_q[1] = 9'h100;
         end
         step(1, j == 0, 1);
      end

      // sync arriving mid-frame at position 5, then the restarted frame and one more
      for (int j = 0; j < 5; j++) begin
         set_rand();
         step(1, j == 0, 1);
      end
      for (int j = 0; j < 2 * FR; j++) begin
         set_rand();
         step(1, j == 0 || j == FR, 1);
      end

      // random traffic: gaps, frames chained by counter wrap, occasional stray sync
      for (int i = 0; i < 400; i++) begin
         bit v, s;
         v = ($urandom_range(0, 9) < 7);
         s = 1'b0;
         if (v && m_pos == 0) s = ($urandom_range(0, 3) != 0);
         else if (v)          s = ($urandom_range(0, 29) == 0);
         set_rand();
         step(v, s, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bfly_stage.md
Name: bfly_stage

Overview:
- Parametrised radix-2 DIF butterfly stage for the streaming FFT datapath.
- Takes NUM parallel complex lanes per beat. Buffers the first half of each frame in an internal delay line. Combines it with the second half as sum and difference.
- Successor to the fixed-width butterfly. Adds:
  - stall-tolerant valid handling (gaps do not lose position),
  - frame sync and a sync-error flag,
  - optional scaling with rounding,
  - saturation or wrap at the output,
  - a frame-last marker.

Parameters:
- IN_WIDTH, 9, input sample width (signed two's complement).
- OUT_WIDTH, 10, output sample width (signed).
- NUM, 16, parallel lanes per beat.
- DATA, 512, complex points per frame.
- COUNT, DATA/NUM, beats per frame. Must be even and ≥2. DATA must be divisible by NUM.
- DELAY, COUNT/2, delay-line depth in beats.
- SCALE, 0. 1 = divide results by 2 with rounding.
- SAT, 1. 1 = saturate on output overflow; 0 = wrap (keep the OUT_WIDTH LSBs).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- din_i  in  [IN_WIDTH-1:0] x NUM  input real, signed.
- din_q  in  [IN_WIDTH-1:0] x NUM  input imag, signed.
- valid_in  in  1  input beat valid.
- sync_in  in  1  marks the current valid beat as beat 0 of a frame.
- do1_re  out  [OUT_WIDTH-1:0] x NUM  sum real (a+b).
- do1_im  out  [OUT_WIDTH-1:0] x NUM  sum imag.
- do2_re  out  [OUT_WIDTH-1:0] x NUM  difference real (a-b).
- do2_im  out  [OUT_WIDTH-1:0] x NUM  difference imag.
- valid_out  out  1  output beat valid.
- last_out  out  1  last output beat of the frame.
- frame_err  out  1  one-cycle pulse: sync_in arrived mid-frame.

Behaviour:
- Clocking: all state updates on rising clk. rstn is sampled synchronously and is active-low.
- Reset (rstn=0 at an edge): beat counter cnt=0. valid_out, last_out, frame_err = 0. All do* registers = 0.
  - Delay-line contents are not cleared. They are never read before being rewritten.
  - Reset mid-frame abandons that frame. The next valid beat is beat 0.
- Beat accepted: a clock edge with valid_in=1.
- valid_in=0 edges:
  - cnt holds, no buffer write.
  - valid_out, last_out, frame_err are 0 the next cycle.
  - do* outputs hold their previous values.
- Beat index: idx = 0 if sync_in=1, else cnt.
- Counter update: cnt <= (idx==COUNT-1) ? 0 : idx+1. Frames run back-to-back with no idle cycle needed.
- Sync error: frame_err=1 for one cycle after an accepted beat with sync_in=1 and cnt≠0. The partial frame is discarded; the buffer is simply overwritten.
- Write phase (idx < DELAY):
  - Store all lanes of din_i/din_q into delay slot idx.
  - No output: valid_out=0 next cycle.
- Compute phase (idx ≥ DELAY):
  - a = delay slot idx-DELAY; b = current din, per lane.
  - Compute full-precision s = a+b and d = a-b, IN_WIDTH+1 bits, separately for re and im.
- Scaling (SCALE=1): r = (x + 1) >>> 1, arithmetic shift, round half up. Result fits IN_WIDTH bits. SCALE=0: r = x.
- Output fit:
  - If OUT_WIDTH ≥ width(r): sign-extend.
  - Else if SAT=1: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Else: keep the OUT_WIDTH LSBs.
- Output timing:
  - Latency is 1 cycle: registered do*, valid_out=1 on the cycle after each compute-phase beat.
  - last_out=1 with the output of idx=COUNT-1.
- Lanes are independent. Lane k output uses only lane k inputs.

Test Plan:
- Reset: hold rstn=0 for 2 edges mid-stream with valid_in=1 → all outputs 0. The first beat after release is treated as idx 0, with no output for DELAY beats.
- Basic frame (NUM=4, DATA=32, DELAY=4, SCALE=0, OUT=10):
  - Stimulus: beats 0-3 re = 10*beat+k, beats 4-7 re = 1, im = 0.
  - Expected at outputs 0..3: do1_re = 10*j+k+1, do2_re = 10*j+k-1; valid_out 1 cycle after each beat; last_out only on the 4th output.
- Gaps: same frame with valid_in=0 for 3 cycles between beats 5 and 6 → valid_out=0 during the gap, values identical to the gap-free case, last_out still on beat 7's output.
- Saturate/wrap (IN=9, OUT=9):
  - SAT=1: a=255, b=255 → do1=255; a=-256, b=255 → do2=-256.
  - SAT=0: a=255, b=255 → do1=-2.
- Scale (SCALE=1, IN=9, OUT=9):
  - 255+255 → 255.
  - -256+-256 → -256.
  - a=3, b=0 → do1=2, do2=2.
  - a=-3, b=0 → do1=-1.
- Sync error: sync_in asserted at cnt=5 → frame_err pulses once, that beat is written as slot 0, no output for it, and the next frame computes correctly.
